// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM state codes,
// framing bytes, register addresses and the frame validity rule.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DHI  = 3'd2,
      ST_DLO  = 3'd3,
      ST_CSUM = 3'd4,
      ST_RESP = 3'd5
   } state_e;

   localparam logic [7:0] SOF = 8'hA5;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [1:0] ADDR_KP = 2'd0;
   localparam logic [1:0] ADDR_KI = 2'd1;
   localparam logic [1:0] ADDR_KD = 2'd2;
   localparam logic [1:0] ADDR_SP = 2'd3;

   // A frame is good when the XOR checksum matches and the address
   // selects one of the four registers (upper six bits clear).
   function automatic logic frame_ok(input logic [7:0] addr,
                                     input logic [7:0] dhi,
                                     input logic [7:0] dlo,
                                     input logic [7:0] csum);
      return (csum == (addr ^ dhi ^ dlo)) && (addr[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream link between a UART and the command parser.
//
// Handshake: rx_valid is a single-cycle strobe that qualifies rx_byte;
// there is no backpressure, the parser takes or drops every strobed
// byte. tx_send is a single-cycle request that qualifies tx_byte and is
// only raised in a cycle where tx_busy is low; tx_busy acts as ready.
interface uart_cmd_parser_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_busy;
   logic       tx_send;
   logic [7:0] tx_byte;

   // UART side: produces received bytes and busy, consumes responses.
   modport master (output rx_valid, output rx_byte, output tx_busy,
                   input  tx_send,  input  tx_byte);

   // Parser side.
   modport slave  (input  rx_valid, input  rx_byte, input  tx_busy,
                   output tx_send,  output tx_byte);
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear
// and flags the TIMEOUT_CYCLES-th such cycle as expired.
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_limit;

   assign at_limit = (cnt_q == LAST);
   // A clear in the expiring cycle (a byte arrived) wins over expiry.
   assign expired  = enable && !clear && at_limit;

   // Next count: clear dominates, saturate at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !at_limit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: receives A5/ADDR/DHI/DLO/CSUM frames and writes
// the PID gain/setpoint registers. Define UART_CMD_ACK_EN to add a RESP
// state that answers every completed frame with ACK or NAK.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned DATA_W         = 16
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   input  logic              tx_busy,
   output logic              tx_send,
   output logic [7:0]        tx_byte,
   output logic              reg_we,
   output logic [1:0]        reg_addr,
   output logic [DATA_W-1:0] kp_o,
   output logic [DATA_W-1:0] ki_o,
   output logic [DATA_W-1:0] kd_o,
   output logic [DATA_W-1:0] sp_o,
   output logic              frame_err,
   output logic [2:0]        state_o
);

   localparam logic [2:0] S_IDLE = ST_IDLE;
   localparam logic [2:0] S_ADDR = ST_ADDR;
   localparam logic [2:0] S_DHI  = ST_DHI;
   localparam logic [2:0] S_DLO  = ST_DLO;
   localparam logic [2:0] S_CSUM = ST_CSUM;
`ifdef UART_CMD_ACK_EN
   localparam logic [2:0] S_RESP = ST_RESP;
`endif

   logic [2:0]        state_q, state_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        dhi_q, dhi_d;
   logic [7:0]        dlo_q, dlo_d;
   logic [DATA_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d;
   logic              reg_we_q, reg_we_d;
   logic [1:0]        reg_addr_q, reg_addr_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        tx_byte_q, tx_byte_d;

   logic [DATA_W-1:0] wdata;
   logic              frame_good;
   logic              tmo_clear, tmo_enable, tmo_expired;

   // Payload is zero-extended or truncated to the register width.
   assign wdata      = DATA_W'({dhi_q, dlo_q});
   assign frame_good = frame_ok(addr_q, dhi_q, dlo_q, rx_byte);

   assign tmo_clear  = rx_valid || (state_q == S_IDLE);
   assign tmo_enable = (state_q == S_ADDR) || (state_q == S_DHI) ||
                       (state_q == S_DLO)  || (state_q == S_CSUM);

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in  (clk_in),
      .reset   (reset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // Frame FSM: byte capture, register write, error and response selection.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dhi_d       = dhi_q;
      dlo_d       = dlo_q;
      kp_d        = kp_q;
      ki_d        = ki_q;
      kd_d        = kd_q;
      sp_d        = sp_q;
      reg_we_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      frame_err_d = 1'b0;
      tx_byte_d   = tx_byte_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_byte == SOF)) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (rx_valid) begin
               addr_d  = rx_byte;
               state_d = S_DHI;
            end
         end
         S_DHI: begin
            if (rx_valid) begin
               dhi_d   = rx_byte;
               state_d = S_DLO;
            end
         end
         S_DLO: begin
            if (rx_valid) begin
               dlo_d   = rx_byte;
               state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               if (frame_good) begin
                  reg_we_d   = 1'b1;
                  reg_addr_d = addr_q[1:0];
                  case (addr_q[1:0])
                     ADDR_KP: kp_d = wdata;
                     ADDR_KI: ki_d = wdata;
                     ADDR_KD: kd_d = wdata;
                     ADDR_SP: sp_d = wdata;
                     default: ;
                  endcase
               end else begin
                  frame_err_d = 1'b1;
               end
`ifdef UART_CMD_ACK_EN
               tx_byte_d = frame_good ? ACK : NAK;
               state_d   = S_RESP;
`else
               state_d   = S_IDLE;
`endif
            end
         end
`ifdef UART_CMD_ACK_EN
         // Incoming bytes are dropped here; leave once the response goes out.
         S_RESP: begin
            if (!tx_busy) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Expiry never coincides with rx_valid, so this only aborts silent gaps.
      if (tmo_expired) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         dhi_q       <= '0;
         dlo_q       <= '0;
         kp_q        <= '0;
         ki_q        <= '0;
         kd_q        <= '0;
         sp_q        <= '0;
         reg_we_q    <= 1'b0;
         reg_addr_q  <= '0;
         frame_err_q <= 1'b0;
         tx_byte_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         dhi_q       <= dhi_d;
         dlo_q       <= dlo_d;
         kp_q        <= kp_d;
         ki_q        <= ki_d;
         kd_q        <= kd_d;
         sp_q        <= sp_d;
         reg_we_q    <= reg_we_d;
         reg_addr_q  <= reg_addr_d;
         frame_err_q <= frame_err_d;
         tx_byte_q   <= tx_byte_d;
      end
   end

`ifdef UART_CMD_ACK_EN
   // Request goes out in the first RESP cycle the transmitter is free.
   assign tx_send = (state_q == S_RESP) && !tx_busy;
   assign tx_byte = tx_byte_q;
`else
   logic [7:0] unused_tx_byte_q;
   logic       unused_tx_busy;
   assign unused_tx_byte_q = tx_byte_q;
   assign unused_tx_busy   = tx_busy;
   assign tx_send          = 1'b0;
   assign tx_byte          = 8'h00;
`endif

   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign kp_o      = kp_q;
   assign ki_o      = ki_q;
   assign kd_o      = kd_q;
   assign sp_o      = sp_q;
   assign frame_err = frame_err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frame table, timeout
// and reset corner cases, then random frames against a reference model.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int T  = 40;
   localparam int DW = 16;

   logic          clk_in = 1'b0;
   logic          reset  = 1'b1;
   logic          reg_we, frame_err;
   logic [1:0]    reg_addr;
   logic [DW-1:0] kp, ki, kd, sp;
   logic [2:0]    state;

   uart_cmd_parser_if u_if ();

   uart_cmd_parser #(.TIMEOUT_CYCLES(T), .DATA_W(DW)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .rx_valid  (u_if.rx_valid),
      .rx_byte   (u_if.rx_byte),
      .tx_busy   (u_if.tx_busy),
      .tx_send   (u_if.tx_send),
      .tx_byte   (u_if.tx_byte),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .kp_o      (kp),
      .ki_o      (ki),
      .kd_o      (kd),
      .sp_o      (sp),
      .frame_err (frame_err),
      .state_o   (state)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;
   int we_cnt = 0, err_cnt = 0, send_cnt = 0, busy_send_cnt = 0;
   logic [15:0] model_regs [4];

   always @(negedge clk_in) begin
      if (!reset) begin
         if (reg_we) we_cnt++;
         if (frame_err) err_cnt++;
         if (u_if.tx_send) begin
            send_cnt++;
            if (u_if.tx_busy) busy_send_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference rule: checksum is XOR of the three body bytes, address < 4.
   function automatic bit model_ok(input logic [39:0] f);
      logic [7:0] a, h, l, c;
      a = f[31:24]; h = f[23:16]; l = f[15:8]; c = f[7:0];
      return (a < 8'd4) && ((a ^ h ^ l) == c);
   endfunction

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic send_byte(input logic [7:0] b);
      u_if.rx_valid = 1'b1;
      u_if.rx_byte  = b;
      @(posedge clk_in); #1;
      u_if.rx_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk_in);
         #1;
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "/kp"}, kp, model_regs[0]);
      check({tag, "/ki"}, ki, model_regs[1]);
      check({tag, "/kd"}, kd, model_regs[2]);
      check({tag, "/sp"}, sp, model_regs[3]);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 4; i++) model_regs[i] = 16'h0000;
      check_regs(tag);
      check({tag, "/tx_send"}, u_if.tx_send, 0);
      check({tag, "/tx_byte"}, u_if.tx_byte, 8'h00);
      check({tag, "/reg_we"}, reg_we, 0);
      check({tag, "/reg_addr"}, reg_addr, 0);
      check({tag, "/frame_err"}, frame_err, 0);
      check({tag, "/state"}, state, ST_IDLE);
   endtask

   task automatic run_frame(input string tag, input logic [39:0] f, input int busy,
                            input bit ok, input logic [1:0] a, input logic [15:0] v,
                            input int n_noise, input bit resp_noise, input int gap_max);
      int we0, err0, snd0;
      logic [7:0] nb;
      we0 = we_cnt; err0 = err_cnt; snd0 = send_cnt;
      for (int j = 0; j < n_noise; j++) begin
         nb = 8'($urandom_range(0, 255));
         if (nb == SOF) nb = 8'h5A;
         send_byte(nb);
      end
      u_if.tx_busy = (busy > 0);
      for (int i = 0; i < 5; i++) begin
         send_byte(f[39-8*i -: 8]);
         if (i < 4 && gap_max > 0) gap($urandom_range(0, gap_max));
      end
      if (ok) model_regs[a] = v;
      @(negedge clk_in);
      check({tag, "/reg_we"}, reg_we, ok);
      check({tag, "/frame_err"}, frame_err, !ok);
      if (ok) check({tag, "/reg_addr"}, reg_addr, a);
      check_regs(tag);
`ifdef UART_CMD_ACK_EN
      check({tag, "/state_resp"}, state, ST_RESP);
      check({tag, "/tx_byte"}, u_if.tx_byte, ok ? ACK : NAK);
      if (busy > 0) begin
         check({tag, "/tx_send_busy"}, u_if.tx_send, 0);
         for (int k = 0; k < busy; k++) begin
            @(posedge clk_in); #1;
            u_if.rx_valid = resp_noise && (k == 0);
            u_if.rx_byte  = SOF;
         end
         @(posedge clk_in); #1;
         u_if.rx_valid = 1'b0;
         u_if.tx_busy  = 1'b0;
         @(negedge clk_in);
      end
      check({tag, "/tx_send"}, u_if.tx_send, 1);
      check({tag, "/tx_byte_send"}, u_if.tx_byte, ok ? ACK : NAK);
      @(posedge clk_in); #1;
      @(negedge clk_in);
      check({tag, "/tx_send_after"}, u_if.tx_send, 0);
      check({tag, "/state_idle"}, state, ST_IDLE);
`else
      check({tag, "/state_idle"}, state, ST_IDLE);
      check({tag, "/tx_send"}, u_if.tx_send, 0);
      check({tag, "/tx_byte"}, u_if.tx_byte, 8'h00);
      if (resp_noise || busy > 0) u_if.tx_busy = 1'b0;
`endif
      @(posedge clk_in); #1;
      check({tag, "/we_pulses"}, we_cnt - we0, ok);
      check({tag, "/err_pulses"}, err_cnt - err0, !ok);
`ifdef UART_CMD_ACK_EN
      check({tag, "/send_pulses"}, send_cnt - snd0, 1);
`else
      check({tag, "/send_pulses"}, send_cnt - snd0, 0);
`endif
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [39:0] frame;
      int          busy;
      bit          noise;
      bit          ok;
      logic [1:0]  addr;
      logic [15:0] val;
   } vec_t;

   vec_t vecs [7];

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int err0, snd0;
      logic [7:0] a, h, l, c;
      logic [39:0] f;

      vecs[0] = '{40'hA5_00_12_34_26, 0,  0, 1'b1, 2'd0, 16'h1234};
      vecs[1] = '{40'hA5_03_00_10_12, 0,  0, 1'b0, 2'd3, 16'h0000};
      vecs[2] = '{40'hA5_01_AB_CD_67, 0,  0, 1'b1, 2'd1, 16'hABCD};
      vecs[3] = '{40'hA5_02_00_07_05, 50, 0, 1'b1, 2'd2, 16'h0007};
      vecs[4] = '{40'hA5_04_00_01_05, 2,  1, 1'b0, 2'd0, 16'h0000};
      vecs[5] = '{40'hA5_03_FF_FF_03, 3,  1, 1'b1, 2'd3, 16'hFFFF};
      vecs[6] = '{40'hA5_00_00_00_00, 0,  0, 1'b1, 2'd0, 16'h0000};

      u_if.rx_valid = 1'b0;
      u_if.rx_byte  = 8'h00;
      u_if.tx_busy  = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_reset_outputs("rst0");
      @(posedge clk_in); #1;
      reset = 1'b0;
      gap(1);

      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].busy, vecs[i].ok,
                   vecs[i].addr, vecs[i].val, vecs[i].noise ? 2 : 0, vecs[i].noise, 0);
      end

      // Timeout after A5 01: T silent cycles expire, one fewer does not.
      err0 = err_cnt; snd0 = send_cnt;
      send_byte(SOF);
      send_byte(8'h01);
      for (int k = 1; k <= T + 1; k++) begin
         @(negedge clk_in);
         if (k == T) begin
            check("tmo/early_err", err_cnt - err0, 0);
            check("tmo/state_dhi", state, ST_DHI);
         end
         if (k == T + 1) begin
            check("tmo/frame_err", frame_err, 1);
            check("tmo/state_idle", state, ST_IDLE);
         end
      end
      @(posedge clk_in); #1;
      gap(5);
      check("tmo/no_send", send_cnt - snd0, 0);
      check("tmo/err_once", err_cnt - err0, 1);
      check_regs("tmo");
      run_frame("tmo_next", 40'hA5_02_BE_EF_53, 0, 1'b1, 2'd2, 16'hBEEF, 0, 0, 0);

      // A byte landing in the expiring cycle is taken instead of timing out.
      err0 = err_cnt;
      send_byte(SOF);
      send_byte(8'h01);
      gap(T - 1);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h04);
      model_regs[1] = 16'h0005;
      @(negedge clk_in);
      check("edge/reg_we", reg_we, 1);
      check_regs("edge");
      @(posedge clk_in); #1;
      gap(3);
      check("edge/no_err", err_cnt - err0, 0);

      // Reset after the DHI byte aborts the frame.
      send_byte(SOF);
      send_byte(8'h02);
      send_byte(8'h00);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_frame");
      @(posedge clk_in); #1;
      reset = 1'b0;
      gap(1);
      run_frame("rst_next", 40'hA5_02_00_07_05, 0, 1'b1, 2'd2, 16'h0007, 0, 0, 0);

      // Reset while a response is held off by tx_busy: no send follows.
      u_if.tx_busy = 1'b1;
      send_byte(SOF); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
      gap(3);
      snd0 = send_cnt;
      #2 reset = 1'b1;
      u_if.tx_busy = 1'b0;
      #1 check_reset_outputs("rst_resp");
      @(posedge clk_in); #1;
      reset = 1'b0;
      gap(5);
      check("rst_resp/no_send", send_cnt - snd0, 0);
      check_regs("rst_resp_after");

      // Random frames, some corrupted, with noise and transmitter stalls.
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(4, 255));
         else a = 8'($urandom_range(0, 3));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         c = a ^ h ^ l;
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         f = {SOF, a, h, l, c};
         run_frame($sformatf("rnd%0d", n), f, $urandom_range(0, 4), model_ok(f), a[1:0], {h, l},
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), 3);
      end

      check("never_send_while_busy", busy_send_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk_in cycles.
REQ-002 SHALL have parameter DATA_W, default 16, width of each gain/setpoint register.
REQ-003 SHALL have port clk_in  input  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse per received byte (driven from the UART data_rdy).
REQ-006 SHALL have port rx_byte  input  8  received byte, valid when rx_valid=1.
REQ-007 SHALL have port tx_busy  input  1  transmitter busy (driven from the UART busy_o).
REQ-008 SHALL have port tx_send  output  1  one-cycle request to transmit tx_byte.
REQ-009 SHALL have port tx_byte  output  8  response byte.
REQ-010 SHALL have port reg_we  output  1  one-cycle pulse when a register is written.
REQ-011 SHALL have port reg_addr  output  2  address of the last write.
REQ-012 SHALL have ports kp_o, ki_o, kd_o, sp_o  output  DATA_W each  PID gains and setpoint.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on any rejected frame.

Function
REQ-014 Frame SHALL be 5 bytes: 0xA5, ADDR, DHI, DLO, CSUM; CSUM = ADDR^DHI^DLO.
REQ-015 FSM states SHALL be IDLE, ADDR, DHI, DLO, CSUM, RESP.
REQ-016 IDLE: rx_valid with 0xA5 -> ADDR; any other byte ignored, no frame_err.
REQ-017 ADDR/DHI/DLO/CSUM: each rx_valid captures the byte and advances one state.
REQ-018 On CSUM byte: frame valid iff checksum matches and ADDR[7:2]==0.
REQ-019 Valid frame: in the cycle after the CSUM rx_valid, addressed register (0=kp,1=ki,2=kd,3=sp) SHALL take {DHI,DLO} zero-extended/truncated to DATA_W, reg_we=1, reg_addr=ADDR[1:0].
REQ-020 Invalid frame: no register change, frame_err=1 in the cycle after the CSUM rx_valid.
REQ-021 Timeout counter SHALL clear on every rx_valid and in IDLE; at TIMEOUT_CYCLES with no byte in ADDR..CSUM -> IDLE, frame_err pulse, partial frame discarded.
REQ-022 rx_valid in the same cycle as timeout expiry SHALL be accepted; no timeout.
REQ-023 RESP: wait while tx_busy=1; first cycle tx_busy=0 assert tx_send for exactly one cycle, then -> IDLE.
REQ-024 tx_byte SHALL be 0x06 (ACK) after valid, 0x15 (NAK) after invalid frame, held stable from RESP entry until tx_send.
REQ-025 Bytes arriving in RESP SHALL be discarded.
REQ-026 Timeout frame_err SHALL NOT generate a response.

Reset
REQ-027 On reset: state IDLE, counter 0, kp_o/ki_o/kd_o/sp_o=0, tx_send=0, tx_byte=0x00, reg_we=0, reg_addr=0, frame_err=0.
REQ-028 Reset mid-frame or mid-RESP SHALL abort immediately with no tx_send and no register write.

Configuration
REQ-029 Macro UART_CMD_ACK_EN: defined -> RESP state and ACK/NAK per REQ-023..025.
REQ-030 Without UART_CMD_ACK_EN: no RESP state, CSUM returns to IDLE directly, tx_send tied 0, tx_byte tied 0x00.

Structure
REQ-031 Package uart_cmd_pkg SHALL hold state enum, SOF (0xA5), ACK (0x06), NAK (0x15), register address constants.
REQ-032 Timeout counter SHALL be sub-module uart_cmd_timeout (inputs clear/enable, output expired).

Verification
REQ-033 Frame A5 00 12 34 26 -> kp_o=0x1234, reg_we one pulse, reg_addr=0, tx_send with tx_byte=0x06.
REQ-034 Frame A5 03 00 10 12 (bad CSUM) -> sp_o unchanged, frame_err pulse, tx_byte=0x15.
REQ-035 A5 01 then idle TIMEOUT_CYCLES -> frame_err pulse, state IDLE, no tx_send; next valid frame accepted.
REQ-036 Valid frame with tx_busy=1 for 50 cycles -> tx_send asserted exactly once, on first cycle tx_busy=0.
REQ-037 Reset asserted after DHI byte -> all outputs reset values, following A5 02 00 07 05 sets kd_o=0x0007.
REQ-038 Build without UART_CMD_ACK_EN -> REQ-033 register update occurs, tx_send never asserted.
